// File: rtl/s27_bist_ctrl.sv
// BIST controller for the s27 core. It runs init and settle, then sweeps every
// input pattern, compacts po0 into a MISR and compares the result with GOLDEN.
`timescale 1ns/1ps
module s27_bist_ctrl #(
  parameter int               N_IN       = 4,
  parameter int               INIT_CYC   = 1,
  parameter int               SETTLE_CYC = 2,
  parameter int               HOLD_CYC   = 2,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] POLY       = 16'h1021,
  parameter logic [SIG_W-1:0] SEED       = 16'h0000,
  parameter logic [SIG_W-1:0] GOLDEN     = 16'h0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             po0,
  output logic [N_IN-1:0]  pat,
  output logic             dut_init,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             pass
);

  localparam int CNT_MAX = (INIT_CYC > SETTLE_CYC) ?
                           ((INIT_CYC > HOLD_CYC) ? INIT_CYC : HOLD_CYC) :
                           ((SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC);
  localparam int CNT_W = $clog2(CNT_MAX + 2);
  localparam logic [CNT_W-1:0] INIT_END   = CNT_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(HOLD_CYC - 1);
  // The index carries one spare bit, so the last pattern is found by compare, not by wrap.
  localparam logic [N_IN:0]    IDX_LAST   = {1'b0, {N_IN{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SETTLE, S_APPLY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN:0]    idx_q, idx_d;
  logic [N_IN-1:0]  pat_q, pat_d;
  logic [SIG_W-1:0] sig_q, sig_d, misr_next;
  logic             dut_init_q, dut_init_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pat_d      = pat_q;
    sig_d      = sig_q;
    dut_init_d = dut_init_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    misr_next  = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^
                 {{(SIG_W-1){1'b0}}, po0};
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_INIT;
          cnt_d      = '0;
          idx_d      = '0;
          pat_d      = '0;
          sig_d      = SEED;
          dut_init_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end
      S_INIT: begin
        if (cnt_q == INIT_END) begin
          cnt_d      = '0;
          dut_init_d = 1'b0;
          state_d    = (SETTLE_CYC == 0) ? S_APPLY : S_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_END) begin
          cnt_d   = '0;
          state_d = S_APPLY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_APPLY: begin
        if (cnt_q == HOLD_END) begin
          cnt_d = '0;
          sig_d = misr_next;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (misr_next == GOLDEN);
          end else begin
            idx_d = idx_q + (N_IN+1)'(1);
            pat_d = idx_q[N_IN-1:0] + N_IN'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      pat_q      <= '0;
      sig_q      <= '0;
      dut_init_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pat_q      <= pat_d;
      sig_q      <= sig_d;
      dut_init_q <= dut_init_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign pat       = pat_q;
  assign dut_init  = dut_init_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Directed bench for s27_bist_ctrl: default timing, a 1-bit sweep, mid-run reset,
// start while busy, and back-to-back runs against a behavioural s27 core.
`timescale 1ns/1ps
module tb_s27_bist_ctrl;

  // Returns {po0, G13, G11, G10} for state {G7,G6,G5} and inputs G3..G0.
  function automatic logic [3:0] s27_eval(input logic [2:0] st, input logic [3:0] g);
    logic g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16;
    g5 = st[0]; g6 = st[1]; g7 = st[2];
    g14 = ~g[0];
    g8  = g14 & g6;
    g12 = ~(g[1] | g7);
    g15 = g12 | g8;
    g16 = g[3] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(g5 | g9);
    g10 = ~(g14 | g11);
    g13 = ~(g[2] | g12);
    return {~g11, g13, g11, g10};
  endfunction

  function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, b};
  endfunction

  // Reference run: cleared core, two settle cycles at pattern 0, then 16 patterns
  // of two cycles each, with a sample on the second cycle.
  function automatic logic [15:0] ref_sig();
    logic [2:0]  st;
    logic [3:0]  r;
    logic [15:0] s;
    st = 3'd0;
    s  = 16'h0000;
    for (int c = 0; c < 2; c++) begin
      r  = s27_eval(st, 4'd0);
      st = r[2:0];
    end
    for (int i = 0; i < 16; i++) begin
      for (int h = 0; h < 2; h++) begin
        r = s27_eval(st, 4'(i));
        if (h == 1) s = ref_misr(s, r[3]);
        st = r[2:0];
      end
    end
    return s;
  endfunction

  localparam logic [15:0] REF_SIG = ref_sig();

  logic clock = 1'b0;
  logic reset, start_a, start_b, start_c, po0_a;
  logic [3:0]  pat_a, pat_c, pat_d;
  logic [0:0]  pat_b;
  logic        init_a, busy_a, done_a, pass_a;
  logic        init_b, busy_b, done_b, pass_b;
  logic        init_c, busy_c, done_c, pass_c;
  logic        init_d, busy_d, done_d, pass_d;
  logic [15:0] sig_a, sig_b, sig_c, sig_d;
  logic [2:0]  core_st;
  logic [3:0]  core_r;
  logic        po0_c;
  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  s27_bist_ctrl u_def (
    .clock(clock), .reset(reset), .start(start_a), .po0(po0_a), .pat(pat_a),
    .dut_init(init_a), .busy(busy_a), .done(done_a), .signature(sig_a), .pass(pass_a));

  s27_bist_ctrl #(.N_IN(1), .HOLD_CYC(1), .GOLDEN(16'h0003)) u_n1 (
    .clock(clock), .reset(reset), .start(start_b), .po0(1'b1), .pat(pat_b),
    .dut_init(init_b), .busy(busy_b), .done(done_b), .signature(sig_b), .pass(pass_b));

  s27_bist_ctrl #(.GOLDEN(REF_SIG)) u_s27 (
    .clock(clock), .reset(reset), .start(start_c), .po0(po0_c), .pat(pat_c),
    .dut_init(init_c), .busy(busy_c), .done(done_c), .signature(sig_c), .pass(pass_c));

  s27_bist_ctrl #(.GOLDEN(REF_SIG ^ 16'h0001)) u_s27_bad (
    .clock(clock), .reset(reset), .start(start_c), .po0(po0_c), .pat(pat_d),
    .dut_init(init_d), .busy(busy_d), .done(done_d), .signature(sig_d), .pass(pass_d));

  // Behavioural s27 core, cleared while dut_init is high.
  assign core_r = s27_eval(core_st, pat_c);
  assign po0_c  = core_r[3];
  always @(posedge clock) begin
    if (init_c) core_st <= 3'd0;
    else        core_st <= core_r[2:0];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_a = 0; start_b = 0; start_c = 0; po0_a = 0;
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      vecs++;
      if ({pat_a, busy_a, done_a, init_a, sig_a, sig_b, sig_c} !== {4'd0, 3'b000, 48'd0}) begin
        errs++;
        $display("FAIL reset_idle cyc %0d: pat=%h busy=%b done=%b sig=%h expected all zero",
                 k, pat_a, busy_a, done_a, sig_a);
      end
    end
  endtask

  task automatic test_default_run();
    logic [3:0] e_pat;
    po0_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    vecs++;
    if ({init_a, busy_a, done_a, pat_a} !== {3'b110, 4'd0}) begin
      errs++;
      $display("FAIL default_init: init/busy/done/pat=%b%b%b/%h expected 110/0",
               init_a, busy_a, done_a, pat_a);
    end
    for (int n = 2; n <= 36; n++) begin
      tick();
      e_pat = (n >= 4 && n <= 35) ? 4'((n - 4) / 2) : (n == 36) ? 4'd15 : 4'd0;
      vecs++;
      if ({init_a, busy_a, done_a, pat_a} !== {1'b0, n < 36, n == 36, e_pat}) begin
        errs++;
        $display("FAIL default_edge %0d: init/busy/done/pat=%b%b%b/%h expected 0%b%b/%h",
                 n, init_a, busy_a, done_a, pat_a, n < 36, n == 36, e_pat);
      end
    end
    vecs++;
    if ({sig_a, pass_a} !== {16'h0000, 1'b1}) begin
      errs++;
      $display("FAIL default_sig: sig=%h pass=%b expected 0000 1", sig_a, pass_a);
    end
  endtask

  task automatic test_n1();
    start_b = 1'b1; tick(); start_b = 1'b0;
    tick(); tick(); tick();
    vecs++;
    if ({busy_b, sig_b} !== {1'b1, 16'h0000}) begin
      errs++;
      $display("FAIL n1_apply: busy=%b sig=%h expected 1 0000", busy_b, sig_b);
    end
    tick();
    vecs++;
    if ({done_b, sig_b, pat_b} !== {1'b0, 16'h0001, 1'b1}) begin
      errs++;
      $display("FAIL n1_sample0: done=%b sig=%h pat=%b expected 0 0001 1", done_b, sig_b, pat_b);
    end
    tick();
    vecs++;
    if ({done_b, busy_b, pass_b, sig_b, pat_b} !== {3'b101, 16'h0003, 1'b1}) begin
      errs++;
      $display("FAIL n1_done: done=%b busy=%b pass=%b sig=%h pat=%b expected 1 0 1 0003 1",
               done_b, busy_b, pass_b, sig_b, pat_b);
    end
  endtask

  task automatic test_midrun_reset();
    po0_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (17) tick();
    vecs++;
    if ({pat_a, sig_a} !== {4'd7, 16'h007F}) begin
      errs++;
      $display("FAIL midrun_pre: pat=%h sig=%h expected 7 007f", pat_a, sig_a);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    vecs++;
    if ({pat_a, busy_a, done_a, init_a, sig_a} !== {4'd0, 3'b000, 16'h0000}) begin
      errs++;
      $display("FAIL midrun_reset: pat=%h busy=%b done=%b sig=%h expected 0 0 0 0000",
               pat_a, busy_a, done_a, sig_a);
    end
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (34) tick();
    vecs++;
    if ({done_a, busy_a, pat_a, sig_a} !== {2'b01, 4'd15, 16'h7FFF}) begin
      errs++;
      $display("FAIL midrun_edge35: done=%b busy=%b pat=%h sig=%h expected 0 1 f 7fff",
               done_a, busy_a, pat_a, sig_a);
    end
    tick();
    vecs++;
    if ({done_a, pass_a, sig_a} !== {2'b10, 16'hFFFF}) begin
      errs++;
      $display("FAIL midrun_done: done=%b pass=%b sig=%h expected 1 0 ffff", done_a, pass_a, sig_a);
    end
  endtask

  task automatic test_start_busy();
    po0_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (9) tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    vecs++;
    if ({init_a, busy_a, pat_a, sig_a} !== {2'b01, 4'd3, 16'h0007}) begin
      errs++;
      $display("FAIL busy_start: init=%b busy=%b pat=%h sig=%h expected 0 1 3 0007",
               init_a, busy_a, pat_a, sig_a);
    end
    repeat (24) tick();
    vecs++;
    if (done_a !== 1'b0) begin
      errs++;
      $display("FAIL busy_edge35: done=%b expected 0", done_a);
    end
    tick();
    vecs++;
    if ({done_a, sig_a} !== {1'b1, 16'hFFFF}) begin
      errs++;
      $display("FAIL busy_done: done=%b sig=%h expected 1 ffff", done_a, sig_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] first;
    int n;
    first = 16'h0000;
    for (int run = 0; run < 2; run++) begin
      start_c = 1'b1; tick(); start_c = 1'b0;
      n = 1;
      if (run == 1) begin
        vecs++;
        if ({done_c, pass_c, busy_c, init_c, sig_c} !== {4'b0011, 16'h0000}) begin
          errs++;
          $display("FAIL b2b_restart: done=%b pass=%b busy=%b init=%b sig=%h expected 0 0 1 1 0000",
                   done_c, pass_c, busy_c, init_c, sig_c);
        end
      end
      for (int k = 0; k < 100 && done_c !== 1'b1; k++) begin
        tick();
        n++;
      end
      vecs++;
      if (n !== 36) begin
        errs++;
        $display("FAIL b2b_latency run %0d: done after %0d edges expected 36", run, n);
      end
      vecs++;
      if ({sig_c, pass_c, sig_d, pass_d} !== {REF_SIG, 1'b1, REF_SIG, 1'b0}) begin
        errs++;
        $display("FAIL b2b_sig run %0d: sig=%h pass=%b bad_pass=%b expected %h 1 0",
                 run, sig_c, pass_c, pass_d, REF_SIG);
      end
      if (run == 1) begin
        vecs++;
        if (sig_c !== first) begin
          errs++;
          $display("FAIL b2b_repeat: sig=%h expected %h", sig_c, first);
        end
      end
      first = sig_c;
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_n1();
    test_midrun_reset();
    test_start_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/s27_bist_ctrl.md
Name: s27_bist_ctrl

Overview:
Self-test stage placed directly upstream and downstream of the s27 benchmark core (`top`).
- Upstream role: after an init/settle phase, drives `top`'s four primary inputs with an exhaustive pattern sweep.
- Downstream role: compacts every `po0` response into a MISR signature and compares the final signature against a golden value.
- It replaces hand-timed bench loops, so hardware runs and regression runs use identical stimulus timing.

Parameters:
- N_IN, 4: pattern width; sweep covers 0 .. 2^N_IN-1.
- INIT_CYC, 1: cycles `dut_init` is held high (harness clears rout_0..2).
- SETTLE_CYC, 2: idle cycles after init, pat=0, before the sweep.
- HOLD_CYC, 2: cycles each pattern is held (>=1).
- SIG_W, 16: MISR width.
- POLY, 16'h1021: MISR feedback taps (x^16+x^12+x^5+1).
- SEED, 16'h0000: MISR value loaded on entry to INIT.
- GOLDEN, 16'h0000: expected final signature.

Ports:
- clock, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request to begin a run; ignored while busy=1.
- po0, input, 1: response from the s27 core.
- pat, output, N_IN: drives input_0..input_{N_IN-1} of the core (bit i -> input_i).
- dut_init, output, 1: high while the core state registers must be held at 0.
- busy, output, 1: high in INIT, SETTLE and APPLY.
- done, output, 1: high in DONE.
- signature, output, SIG_W: current MISR value.
- pass, output, 1: valid while done=1; 1 when signature==GOLDEN.

Behaviour:
- Reset: a synchronous reset, whenever asserted (including mid-run), forces:
  - state=IDLE, pat=0, dut_init=0, busy=0, done=0, pass=0;
  - signature=0, counters=0.
  - Reset has priority over start.
- All outputs are registered. No combinational path from po0 or start to any output.
- State IDLE:
  - pat=0.
  - start=1 -> INIT on the next edge; signature<=SEED.
- State INIT:
  - dut_init=1, pat=0.
  - Lasts exactly INIT_CYC cycles, then -> SETTLE.
- State SETTLE:
  - dut_init=0, pat=0.
  - Lasts exactly SETTLE_CYC cycles, then -> APPLY.
  - SETTLE_CYC=0 skips straight to APPLY.
- State APPLY:
  - Pattern index idx runs 0 .. 2^N_IN-1. pat=idx[N_IN-1:0]. Each idx is held HOLD_CYC cycles.
  - On the edge ending the last hold cycle of each idx, the MISR samples po0 (value present in that cycle):
    sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ {{SIG_W-1{1'b0}},po0}
  - No other cycle updates the MISR.
  - idx counter is N_IN+1 bits wide, so terminal detection never relies on wrap-around.
  - The edge that samples idx=2^N_IN-1 moves to DONE. pat stays at 2^N_IN-1 in DONE until restart.
- Cycle count: from the start-sampling edge to done=1 is INIT_CYC + SETTLE_CYC + 2^N_IN*HOLD_CYC + 1 edges. With defaults this is 36.
- State DONE:
  - done=1, busy=0.
  - pass is registered from the final signature on entry and held.
  - start=1 -> INIT (new run, MISR reseeded, done/pass cleared on the same edge).
- start asserted while busy: ignored, with no effect on counters or MISR.
- Exactly 2^N_IN MISR updates per run. The signature holds its value outside APPLY updates.

Test Plan:
- Reset then idle: hold reset 2 cycles, start=0 for 10 cycles -> pat=0, busy=0, done=0, signature=0 throughout.
- Defaults, po0 tied 0, single start pulse:
  - dut_init=1 for exactly 1 cycle, then pat=0 for 2 cycles.
  - pat steps 0..15, each held exactly 2 cycles.
  - done rises 36 edges after start; signature=16'h0000, pass=1.
- N_IN=1, HOLD_CYC=1, po0 tied 1 -> two samples give signature 16'h0001 then 16'h0003. With GOLDEN=16'h0003, pass=1.
- Mid-run reset: assert reset during APPLY at idx=7 -> next cycle IDLE, pat=0, busy=0, signature=0. A fresh start then completes normally with the same timing as a clean run.
- Start while busy: pulse start at idx=3 -> no restart; done still arrives at edge 36 and signature is unchanged versus a clean run.
- Connected to s27 core with GOLDEN set to the signature from the reference model:
  - Run twice back-to-back (start in DONE) -> both runs end with identical signature and pass=1.
  - Setting GOLDEN ^ 16'h0001 -> pass=0.
